aqp_clken_gen: RTL and testbench

- Parametrised multi-channel fractional clock-enable generator on the single system clock.
- Each channel runs a phase accumulator and emits one-cycle clock-enable pulses at f_clk * inc / 2^ACC_W, so sub-rates such as video, audio and CPU rates come from one clock without extra DCM/PLL resources.
- An external lock input gates all outputs through a lock-stabilisation state machine.

---
 rtl/aqp_clken_gen_if.sv | 27 ++
 rtl/aqp_clken_gen.sv | 133 +++++++++++++
 tb/tb_aqp_clken_gen.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aqp_clken_gen_if.sv
// Bus bundle for aqp_clken_gen: lock input, increment write port,
// channel controls and the registered enable outputs.
interface aqp_clken_gen_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 24
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              locked_in;
    logic              ready;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [ACC_W-1:0]  wr_inc;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic [NUM_CH-1:0] clken;

    modport master (
        output locked_in, wr_en, wr_ch, wr_inc, ch_en, sync,
        input  ready, clken
    );

    modport slave (
        input  locked_in, wr_en, wr_ch, wr_inc, ch_en, sync,
        output ready, clken
    );
endinterface

// File: rtl/aqp_clken_gen.sv
// Multi-channel fractional clock-enable generator. Each channel adds its
// increment into a phase accumulator every cycle and pulses clken on carry,
// giving a rate of f_clk * inc / 2^ACC_W. Nothing runs until the upstream
// lock has been stable for LOCK_CYCLES consecutive cycles.
module aqp_clken_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    aqp_clken_gen_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              ready_q;
    logic              ready_next;
    logic              stay_run;

    logic [ACC_W-1:0]  inc [NUM_CH];
    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [NUM_CH-1:0] clken_q;

    // Lock state machine register and its stabilisation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Lock qualification: any dropped cycle of locked_in restarts the wait
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (bus.locked_in) begin
                    next_state = STABILIZE;
                    cnt_next   = '0;
                end
            end
            STABILIZE: begin
                if (!bus.locked_in) begin
                    next_state = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == LOCK_LAST) begin
                    next_state = RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!bus.locked_in) begin
                    next_state = WAIT_LOCK;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Accumulators only advance on edges that both start and end in RUN,
    // so entering RUN always begins from a zero phase
    always_comb begin
        ready_next = (next_state == RUN);
        stay_run   = (state == RUN) && (next_state == RUN);
    end

    // ready mirrors RUN as a register so it changes on the same edge as the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic             wr_hit;
            logic [ACC_W:0]   sum;

            assign wr_hit = bus.wr_en && (bus.wr_ch == CH_W'(gi));
            assign sum    = {1'b0, acc[gi]} + {1'b0, inc[gi]};

            // Increment register; out-of-range channel indices match no channel
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    inc[gi] <= '0;
                end else if (wr_hit) begin
                    inc[gi] <= bus.wr_inc;
                end
            end

            // Phase accumulator: carry out of the add is the enable pulse
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc[gi]     <= '0;
                    clken_q[gi] <= 1'b0;
                end else if (!stay_run || bus.sync || !bus.ch_en[gi]) begin
                    acc[gi]     <= '0;
                    clken_q[gi] <= 1'b0;
                end else begin
                    acc[gi]     <= sum[ACC_W-1:0];
                    clken_q[gi] <= sum[ACC_W];
                end
            end
        end
    endgenerate

    assign bus.ready = ready_q;
    assign bus.clken = clken_q;
endmodule

// File: tb/tb_aqp_clken_gen.sv
// Testbench for aqp_clken_gen: a 4-channel and a 3-channel instance share
// one stimulus stream and are compared every cycle against a reference
// model built from the lock-streak and modular-accumulation rules.
module tb_aqp_clken_gen;
    localparam int ACC_W       = 24;
    localparam int LOCK_CYCLES = 16;
    localparam longint MASK    = (longint'(1) << ACC_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        locked_in;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [23:0] wr_inc;
    logic [3:0]  ch_en;
    logic        sync;

    int vec_count  = 0;
    int miscompare = 0;

    // Reference model state: consecutive locked samples plus per-channel
    // increments/accumulators for instance a (index 0) and b (index 1)
    int          streak;
    longint      m_inc [2][4];
    longint      m_acc [2][4];
    logic [3:0]  m_clken [2];
    int          n_ch [2] = '{4, 3};

    always #5 clk = ~clk;

    aqp_clken_gen_if #(.NUM_CH(4), .ACC_W(ACC_W)) bus_a ();
    aqp_clken_gen_if #(.NUM_CH(3), .ACC_W(ACC_W)) bus_b ();

    assign bus_a.locked_in = locked_in;
    assign bus_a.wr_en     = wr_en;
    assign bus_a.wr_ch     = wr_ch;
    assign bus_a.wr_inc    = wr_inc;
    assign bus_a.ch_en     = ch_en;
    assign bus_a.sync      = sync;

    assign bus_b.locked_in = locked_in;
    assign bus_b.wr_en     = wr_en;
    assign bus_b.wr_ch     = wr_ch;
    assign bus_b.wr_inc    = wr_inc;
    assign bus_b.ch_en     = ch_en[2:0];
    assign bus_b.sync      = sync;

    aqp_clken_gen #(.NUM_CH(4), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    aqp_clken_gen #(.NUM_CH(3), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompare++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        streak = 0;
        for (int d = 0; d < 2; d++) begin
            m_clken[d] = '0;
            for (int i = 0; i < 4; i++) begin
                m_inc[d][i] = 0;
                m_acc[d][i] = 0;
            end
        end
    endfunction

    // One clock edge of the model: outputs run once the lock streak exceeds
    // LOCK_CYCLES; an add only happens when running both before and after
    function automatic void modelStep();
        bit running_before, running_after;
        longint s;
        running_before = (streak > LOCK_CYCLES);
        if (locked_in) begin
            if (streak < 1000000) streak++;
        end else begin
            streak = 0;
        end
        running_after = (streak > LOCK_CYCLES);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < n_ch[d]; i++) begin
                if (running_before && running_after && !sync && ch_en[i]) begin
                    s = m_acc[d][i] + m_inc[d][i];
                    m_clken[d][i] = (s > MASK);
                    m_acc[d][i]   = s & MASK;
                end else begin
                    m_clken[d][i] = 1'b0;
                    m_acc[d][i]   = 0;
                end
            end
            if (wr_en && int'(wr_ch) < n_ch[d]) begin
                m_inc[d][wr_ch] = longint'(wr_inc);
            end
        end
    endfunction

    task automatic checkAll(input string tag);
        checkOutput({tag, "_ready_a"}, 32'(bus_a.ready), 32'(streak > LOCK_CYCLES));
        checkOutput({tag, "_clken_a"}, 32'(bus_a.clken), 32'(m_clken[0]));
        checkOutput({tag, "_ready_b"}, 32'(bus_b.ready), 32'(streak > LOCK_CYCLES));
        checkOutput({tag, "_clken_b"}, 32'(bus_b.clken), 32'(m_clken[1][2:0]));
    endtask

    // Runs n cycles with the current inputs, checking both DUTs on each negedge
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkAll("cyc");
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic writeInc(input logic [1:0] ch, input logic [23:0] value);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_inc = value;
        applyStimulus(1);
        wr_en  = 1'b0;
    endtask

    // Holds lock high, measures edges until ready, then checks the half-rate
    // pattern of channel 0 (inc 0x800000) from a zero phase
    task automatic lockAndCheck(input string tag);
        int first_edge;
        first_edge = 0;
        locked_in  = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1);
            if (bus_a.ready) begin
                first_edge = e;
                break;
            end
        end
        checkOutput({tag, "_lock_latency"}, 32'(first_edge), 32'(LOCK_CYCLES + 1));
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1);
            checkOutput({tag, "_ch0_pattern"}, 32'(bus_a.clken[0]), 32'(k % 2 == 0));
        end
    endtask

    initial begin
        int pulses;
        int last;
        longint expect_pulses;

        reset     = 1'b0;
        locked_in = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_inc    = '0;
        ch_en     = '0;
        sync      = 1'b0;
        modelReset();
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        checkAll("reset_state");
        reset = 1'b0;

        // Lock latency and half-rate channel 0
        writeInc(2'd0, 24'h800000);
        ch_en = 4'b0001;
        lockAndCheck("first_lock");

        // One-third rate on channel 1: exact pulse count and spacing
        writeInc(2'd1, 24'h555556);
        ch_en  = 4'b0011;
        pulses = 0;
        last   = -1;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(1);
            if (bus_a.clken[1]) begin
                pulses++;
                if (last >= 0) checkOutput("ch1_spacing", 32'(c - last), 32'd3);
                last = c;
            end
        end
        expect_pulses = (longint'(3000) * longint'(24'h555556)) >> ACC_W;
        checkOutput("ch1_count", 32'(pulses), 32'(expect_pulses));

        // Single-cycle lock drop restarts qualification and phase
        locked_in = 1'b0;
        applyStimulus(1);
        checkOutput("drop_ready", 32'(bus_a.ready), 32'd0);
        checkOutput("drop_clken", 32'(bus_a.clken), 32'd0);
        lockAndCheck("relock");

        // Channels 0 and 2 at half rate in opposite phase, then sync
        ch_en = 4'b0001;
        writeInc(2'd2, 24'h800000);
        if (m_acc[0][0] != 64'h800000) applyStimulus(1);
        ch_en = 4'b0101;
        applyStimulus(4);
        sync = 1'b1;
        applyStimulus(1);
        sync = 1'b0;
        checkOutput("sync_clken", 32'(bus_a.clken), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1);
            checkOutput("sync_aligned", 32'({bus_a.clken[2], bus_a.clken[0]}), (k % 2 == 0) ? 32'd3 : 32'd0);
        end

        // Channel index 3 is out of range for the 3-channel instance
        ch_en = 4'b0111;
        writeInc(2'd3, 24'hFFFFFF);
        applyStimulus(12);

        // Reset during STABILIZE and during RUN clears increments
        doReset();
        locked_in = 1'b1;
        applyStimulus(5);
        doReset();
        ch_en     = 4'b1111;
        locked_in = 1'b1;
        applyStimulus(40);
        checkOutput("no_pulse_after_reset", 32'(bus_a.clken), 32'd0);
        for (int i = 0; i < 4; i++) writeInc(2'(i), 24'($urandom));
        applyStimulus(30);
        doReset();
        locked_in = 1'b1;
        applyStimulus(30);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            locked_in = ($urandom_range(0, 99) != 0);
            sync      = ($urandom_range(0, 31) == 0);
            wr_en     = ($urandom_range(0, 7) == 0);
            wr_ch     = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       wr_inc = 24'h000000;
                1:       wr_inc = 24'hFFFFFF;
                2:       wr_inc = 24'h800000;
                default: wr_inc = 24'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                applyStimulus(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end
endmodule
